// File: rtl/ste_slot_arbiter_pkg.sv
// Shared constants for the STE bus-slot arbiter: default sizes, requester
// indices and the bus_cycle phases that frame one memory slot.
package ste_slot_arbiter_pkg;

    localparam int NREQ_DEF = 3;
    localparam int AW_DEF   = 23;

    localparam int SND = 0;
    localparam int FDC = 1;
    localparam int BLT = 2;

    localparam logic [3:0] ARB  = 4'd0;
    localparam logic [3:0] DATA = 4'd3;
    localparam logic [3:0] ACK  = 4'd4;

    function automatic int next_ptr(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/ste_slot_arbiter_if.sv
// Requester/memory bundle of the slot arbiter; slave is the arbiter side,
// master is the side driving the bus phase, requests and RAM data.
interface ste_slot_arbiter_if
    import ste_slot_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF
);
    logic [3:0]         bus_cycle;
    logic               hsync;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    urgent;
    logic [NREQ*AW-1:0] req_addr;
    logic [15:0]        mem_data;
    logic               mem_read;
    logic [AW-1:0]      mem_addr;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    ack;
    logic [15:0]        rd_data;

    modport slave (
        input  bus_cycle, hsync, req, urgent, req_addr, mem_data,
        output mem_read, mem_addr, grant, ack, rd_data
    );

    modport master (
        output bus_cycle, hsync, req, urgent, req_addr, mem_data,
        input  mem_read, mem_addr, grant, ack, rd_data
    );
endinterface

// File: rtl/ste_slot_arbiter_rr_pick.sv
// Round-robin picker: first set bit of the eligible mask at or after rr_ptr,
// wrapping modulo NREQ, returned both one-hot and as an index.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] winner,
    output logic [PW-1:0]   winner_idx,
    output logic            found
);
    int              idx;
    logic [NREQ-1:0] sh;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        idx        = 0;
        sh         = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            sh  = eligible >> idx;
            if (!found && sh[0]) begin
                found      = 1'b1;
                winner     = NREQ'(1) << idx;
                winner_idx = PW'(idx);
            end
        end
    end
endmodule

// File: rtl/ste_slot_arbiter.sv
// Grants the 0..3 bus window to one DMA-style requester per 16-cycle frame,
// with urgent override, round-robin fairness and a fixed-latency ack.
module ste_slot_arbiter
    import ste_slot_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF
) (
    input logic              clk,
    input logic              reset,
    ste_slot_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] urg_req, eligible, win_onehot;
    logic [PW-1:0]   win_idx, rr_ptr;
    logic            win_any;
    logic [AW-1:0]   addr_sel;

    logic [NREQ-1:0] grant_q, ack_q;
    logic            mem_read_q;
    logic [AW-1:0]   mem_addr_q;
    logic [15:0]     rd_data_q;
    logic            active, req_held, seq_ok;
    logic [3:0]      prev_bc;

    logic arb_edge, in_seq, phase_ok, slot_end, owner_req;

    // Urgent requesters, when present, shut out everyone else.
    always_comb begin
        urg_req  = bus.req & bus.urgent;
        eligible = (urg_req != '0) ? urg_req : bus.req;
    end

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .eligible   (eligible),
        .rr_ptr     (rr_ptr),
        .winner     (win_onehot),
        .winner_idx (win_idx),
        .found      (win_any)
    );

    always_comb begin
        addr_sel = '0;
        for (int i = 0; i < NREQ; i++)
            if (win_onehot[i]) addr_sel = bus.req_addr[i*AW +: AW];
    end

    // A slot is only trusted while bus_cycle has advanced by one on every edge;
    // a broken slot lingers until the next phase-0 edge and never acks.
    assign in_seq    = (bus.bus_cycle == prev_bc + 4'd1);
    assign phase_ok  = seq_ok && in_seq;
    assign owner_req = |(bus.req & grant_q);
    assign arb_edge  = (bus.bus_cycle == ARB) && bus.hsync && win_any;
    assign slot_end  = active && ((bus.bus_cycle == ACK && phase_ok) || bus.bus_cycle == ARB);

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q    <= '0;
            ack_q      <= '0;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
            rd_data_q  <= '0;
            rr_ptr     <= '0;
            active     <= 1'b0;
            req_held   <= 1'b0;
            seq_ok     <= 1'b0;
            prev_bc    <= '0;
        end else begin
            prev_bc <= bus.bus_cycle;
            ack_q   <= '0;
            if (active) begin
                if (!in_seq)    seq_ok   <= 1'b0;
                if (!owner_req) req_held <= 1'b0;
                if (phase_ok && bus.bus_cycle == DATA) rd_data_q <= bus.mem_data;
                mem_read_q <= (bus.bus_cycle[3:2] == 2'b00);
            end
            if (slot_end) begin
                if (bus.bus_cycle == ACK && phase_ok && req_held && owner_req)
                    ack_q <= grant_q;
                grant_q    <= '0;
                mem_addr_q <= '0;
                mem_read_q <= 1'b0;
                active     <= 1'b0;
            end
            // A new slot may start on the same edge a broken one is retired.
            if (arb_edge) begin
                grant_q    <= win_onehot;
                mem_addr_q <= addr_sel;
                mem_read_q <= 1'b1;
                active     <= 1'b1;
                req_held   <= 1'b1;
                seq_ok     <= 1'b1;
                rr_ptr     <= PW'(next_ptr(int'(win_idx), NREQ));
            end
        end
    end

    assign bus.grant    = grant_q;
    assign bus.ack      = ack_q;
    assign bus.mem_read = mem_read_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.rd_data  = rd_data_q;
endmodule

// File: tb/tb_ste_slot_arbiter.sv
// Directed and randomized bench for ste_slot_arbiter against a slot-level
// reference model.
module tb_ste_slot_arbiter;
    import ste_slot_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int AW = 23;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ste_slot_arbiter_if #(.NREQ(N), .AW(AW)) bus ();
    ste_slot_arbiter #(.NREQ(N), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    logic [3:0]    bc = 4'd0;
    logic          hs = 1'b1;
    logic [N-1:0]  rq = '0;
    logic [N-1:0]  ug = '0;
    logic [AW-1:0] addr [N];
    logic [15:0]   md = '0;

    // Reference model state: one slot at a time, tracked by its age in edges.
    int            m_owner = -1;
    int            m_age = 0;
    int            m_rr = 0;
    bit            m_ok = 1'b0;
    bit            m_held = 1'b0;
    bit            m_mr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [15:0]   m_rd = '0;
    logic [N-1:0]  m_ack = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit bitof(input logic [N-1:0] v, input int i);
        logic [N-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    task automatic model_edge();
        int  w;
        int  i;
        bit  any_urg;
        m_ack = '0;
        if (reset) begin
            m_owner = -1;
            m_rr    = 0;
            m_rd    = '0;
            m_mr    = 1'b0;
            return;
        end
        if (m_owner >= 0) begin
            m_age++;
            if (int'(bc) != (m_age % 16)) m_ok = 1'b0;
            if (!bitof(rq, m_owner)) m_held = 1'b0;
            if (m_ok && bc == 4'd3) m_rd = md;
            if (m_ok && bc == 4'd4) begin
                if (m_held) m_ack = N'(1) << m_owner;
                m_owner = -1;
            end else if (bc == 4'd0) begin
                m_owner = -1;
            end
        end
        if (bc == 4'd0 && hs) begin
            any_urg = |(rq & ug);
            w = -1;
            for (int k = 0; k < N; k++) begin
                i = (m_rr + k) % N;
                if (w < 0 && bitof(rq, i) && (!any_urg || bitof(ug, i))) w = i;
            end
            if (w >= 0) begin
                m_owner = w;
                m_age   = 0;
                m_ok    = 1'b1;
                m_held  = 1'b1;
                m_addr  = addr[w];
                m_rr    = (w + 1) % N;
            end
        end
        m_mr = (m_owner >= 0) && (bc < 4'd4);
    endtask

    task automatic step();
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        bus.bus_cycle = bc;
        bus.hsync     = hs;
        bus.req       = rq;
        bus.urgent    = ug;
        bus.mem_data  = md;
        for (int j = 0; j < N; j++) bus.req_addr[j*AW +: AW] = addr[j];
        model_edge();
        @(posedge clk);
        #1;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        ea = (m_owner >= 0) ? m_addr : '0;
        chk("grant", 32'(bus.grant), 32'(eg));
        chk("ack", 32'(bus.ack), 32'(m_ack));
        chk("mem_read", 32'(bus.mem_read), 32'(m_mr));
        chk("mem_addr", 32'(bus.mem_addr), 32'(ea));
        chk("rd_data", 32'(bus.rd_data), 32'(m_rd));
        bc = bc + 4'd1;
    endtask

    task automatic sync0();
        while (bc != 4'd0) step();
    endtask

    task automatic run_slot(output logic [N-1:0] g, output logic [N-1:0] a,
                            output logic [15:0] d3, output logic [15:0] rd);
        g = '0; a = '0; d3 = '0; rd = '0;
        sync0();
        for (int c = 0; c < 16; c++) begin
            md = 16'($urandom);
            if (c == 3) d3 = md;
            step();
            if (c == 0) g = bus.grant;
            if (c == 4) begin
                a  = bus.ack;
                rd = bus.rd_data;
            end
        end
    endtask

    logic [N-1:0] g, a, last_ack, nrq;
    logic [15:0]  d3, rd;
    int           cnt_mr, cnt_ack;
    logic [N-1:0] exp_alt [4];

    initial begin
        reset = 1'b1;
        for (int j = 0; j < N; j++) addr[j] = AW'($urandom);
        repeat (3) step();
        chk("reset_grant", 32'(bus.grant), 32'h0);
        chk("reset_rd_data", 32'(bus.rd_data), 32'h0);
        chk("reset_mem_addr", 32'(bus.mem_addr), 32'h0);
        reset = 1'b0;
        sync0();

        // Two plain requesters alternate.
        exp_alt[0] = 3'b001; exp_alt[1] = 3'b010; exp_alt[2] = 3'b001; exp_alt[3] = 3'b010;
        rq = 3'b011;
        for (int s = 0; s < 4; s++) begin
            run_slot(g, a, d3, rd);
            chk("alt_grant", 32'(g), 32'(exp_alt[s]));
            chk("alt_ack", 32'(a), 32'(exp_alt[s]));
            chk("alt_rd_data", 32'(rd), 32'(d3));
        end

        // Urgent blitter wins from rr_ptr=0, pointer wraps back to 0.
        reset = 1'b1; step(); reset = 1'b0;
        rq = 3'b111;
        ug = 3'b001 << BLT;
        run_slot(g, a, d3, rd);
        chk("urgent_grant", 32'(g), 32'h4);
        chk("urgent_rr_ptr", 32'(dut.rr_ptr), 32'h0);
        ug = '0;
        run_slot(g, a, d3, rd);
        chk("after_urgent_grant", 32'(g), 32'h1);

        // Video owns the window for three lines.
        rq = 3'b001 << SND;
        hs = 1'b0;
        cnt_mr = 0; cnt_ack = 0;
        repeat (48) begin
            step();
            if (bus.mem_read) cnt_mr++;
            if (bus.ack != '0) cnt_ack++;
        end
        chk("hsync_low_mem_read", 32'(cnt_mr), 32'h0);
        chk("hsync_low_ack", 32'(cnt_ack), 32'h0);
        hs = 1'b1;
        run_slot(g, a, d3, rd);
        chk("hsync_rise_grant", 32'(g), 32'h1);

        // Floppy drops its request mid-slot.
        rq = 3'b110;
        sync0();
        step();
        chk("drop_grant", 32'(bus.grant), 32'h2);
        step();
        rq = 3'b001 << BLT;
        step();
        step();
        chk("drop_mem_read_c3", 32'(bus.mem_read), 32'h1);
        step();
        chk("drop_ack", 32'(bus.ack), 32'h0);
        run_slot(g, a, d3, rd);
        chk("drop_next_grant", 32'(g), 32'h4);

        // Reset in the middle of a slot.
        rq = 3'b001 << FDC;
        sync0();
        step();
        step();
        reset = 1'b1;
        step();
        chk("rst_slot_grant", 32'(bus.grant), 32'h0);
        chk("rst_slot_mem_read", 32'(bus.mem_read), 32'h0);
        chk("rst_slot_rr_ptr", 32'(dut.rr_ptr), 32'h0);
        reset = 1'b0;
        cnt_ack = 0;
        while (bc != 4'd0) begin
            step();
            if (bus.ack != '0) cnt_ack++;
        end
        chk("rst_slot_ack", 32'(cnt_ack), 32'h0);
        rq = 3'b111;
        run_slot(g, a, d3, rd);
        chk("rst_resume_grant", 32'(g), 32'h1);

        // Top-of-range address held for the slot only.
        rq = 3'b001;
        addr[SND] = 23'h7FFFFF;
        sync0();
        for (int c = 0; c < 5; c++) begin
            step();
            chk("max_addr", 32'(bus.mem_addr), (c < 4) ? 32'h7FFFFF : 32'h0);
        end

        // bus_cycle jumps from 1 to 9: slot retires at phase 0 with no ack.
        rq = 3'b010;
        sync0();
        step();
        step();
        bc = 4'd9;
        cnt_ack = 0;
        while (bc != 4'd0) begin
            step();
            if (bus.ack != '0) cnt_ack++;
        end
        chk("jump_grant_held", 32'(bus.grant), 32'h2);
        rq = '0;
        step();
        if (bus.ack != '0) cnt_ack++;
        chk("jump_ack", 32'(cnt_ack), 32'h0);
        chk("jump_grant_end", 32'(bus.grant), 32'h0);

        // Randomized traffic with requesters that hold until ack.
        last_ack = '0;
        for (int t = 0; t < 1600; t++) begin
            nrq = '0;
            for (int j = 0; j < N; j++) begin
                bit nb;
                if (bitof(last_ack, j))   nb = ($urandom_range(1, 0) == 1);
                else if (!bitof(rq, j))   nb = ($urandom_range(3, 0) == 0);
                else                      nb = ($urandom_range(63, 0) != 0);
                if (nb) nrq = nrq | (N'(1) << j);
            end
            rq = nrq;
            ug = rq & N'($urandom) & N'($urandom);
            hs = ($urandom_range(7, 0) != 0);
            md = 16'($urandom);
            addr[$urandom_range(N-1, 0)] = AW'($urandom);
            reset = ($urandom_range(499, 0) == 0);
            if ($urandom_range(299, 0) == 0) bc = 4'($urandom);
            step();
            last_ack = bus.ack;
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
